// File: rtl/npc_ctrl.sv
// Next-PC controller: owns the PC register and EPC, and selects the 5:1 next-PC mux input.
// It also holds redirects that arrive during a stall and flushes IF/ID for one cycle after an exception.
//
// state | meaning
// RUN   | normal fetch; redirects are taken immediately, or latched if stalled
// PEND  | a redirect is held in pend_tgt until the stall releases
// EXC   | first cycle after an exception; IF/ID flushed
module npc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic        jmp_i,
  input  logic        jr_i,
  input  logic        eret_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] br_tgt_i,
  input  logic [31:0] jmp_tgt_i,
  input  logic [31:0] jr_tgt_i,
  input  logic [31:0] pc_mux_i,
  output logic [2:0]  choose_o,
  output logic [31:0] tgt_e_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] epc_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, EXC = 2'd2} state_t;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_JMP = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b011;
  localparam logic [2:0] SEL_E   = 3'b100;

  state_t      state, state_nxt;
  logic [31:0] pend_tgt;
  logic        has_redir;
  logic [31:0] redir_tgt;
  logic        exc_take;
  logic        pc_load;
  logic        pend_load;

  assign pc_plus4_o = pc_o + 32'd4;
  assign has_redir  = eret_i | jr_i | jmp_i | br_taken_i;

  // Target of the winning redirect, used when it must be held over a stall.
  always_comb begin
    redir_tgt = br_tgt_i;
    if (eret_i)    redir_tgt = epc_o;
    else if (jr_i) redir_tgt = jr_tgt_i;
    else if (jmp_i) redir_tgt = jmp_tgt_i;
  end

  // An exception is accepted in RUN at any time, and in PEND only while still stalled.
  assign exc_take  = exc_i & ((state == RUN) | ((state == PEND) & stall_i));
  assign pc_load   = exc_take | ~stall_i;
  assign pend_load = (state == RUN) & ~exc_i & stall_i & has_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_o     <= RESET_PC;
      epc_o    <= 32'd0;
      pend_tgt <= 32'd0;
    end else begin
      state <= state_nxt;
      if (pc_load)   pc_o     <= pc_mux_i;
      if (exc_take)  epc_o    <= exc_pc_i;
      if (pend_load) pend_tgt <= redir_tgt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (exc_i) state_nxt = EXC;
               else if (stall_i && has_redir) state_nxt = PEND;
      PEND:    if (exc_take) state_nxt = EXC;
               else if (!stall_i) state_nxt = RUN;
      EXC:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    choose_o = SEL_SEQ;
    tgt_e_o  = EXC_VECTOR;
    flush_o  = 1'b0;
    case (state)
      RUN: begin
        if (exc_i) begin
          choose_o = SEL_E;
        end else if (!stall_i) begin
          if (eret_i) begin
            choose_o = SEL_E;
            tgt_e_o  = epc_o;
          end else if (jr_i)       choose_o = SEL_JR;
          else if (jmp_i)          choose_o = SEL_JMP;
          else if (br_taken_i)     choose_o = SEL_BR;
        end
      end
      PEND: begin
        if (exc_take) begin
          choose_o = SEL_E;
        end else if (!stall_i) begin
          choose_o = SEL_E;
          tgt_e_o  = pend_tgt;
        end
      end
      EXC:     flush_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// Testbench for npc_ctrl: directed scenarios followed by random redirect/stall traffic,
// all checked against a behavioural model of the fetch redirect rules.
module tb_npc_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, br_taken_i = 1'b0, jmp_i = 1'b0, jr_i = 1'b0;
  logic        eret_i = 1'b0, exc_i = 1'b0;
  logic [31:0] exc_pc_i = '0, br_tgt_i = '0, jmp_tgt_i = '0, jr_tgt_i = '0;
  logic [31:0] pc_mux_i;
  logic [2:0]  choose_o;
  logic [31:0] tgt_e_o, pc_o, pc_plus4_o, epc_o;
  logic        flush_o;

  int total = 0;
  int bad   = 0;

  // Environment mux feeding the selected next PC back into the controller.
  always_comb begin
    case (choose_o)
      3'b001:  pc_mux_i = br_tgt_i;
      3'b010:  pc_mux_i = jmp_tgt_i;
      3'b011:  pc_mux_i = jr_tgt_i;
      3'b100:  pc_mux_i = tgt_e_o;
      default: pc_mux_i = pc_plus4_o;
    endcase
  end

  npc_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i), .jmp_i(jmp_i),
    .jr_i(jr_i), .eret_i(eret_i), .exc_i(exc_i), .exc_pc_i(exc_pc_i), .br_tgt_i(br_tgt_i),
    .jmp_tgt_i(jmp_tgt_i), .jr_tgt_i(jr_tgt_i), .pc_mux_i(pc_mux_i), .choose_o(choose_o),
    .tgt_e_o(tgt_e_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .epc_o(epc_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  // Model: the PC, EPC, an optional held redirect, and whether the last cycle took an exception.
  logic [31:0] m_pc, m_epc, m_pend_tgt;
  bit          m_pend, m_after_exc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epc = 0; m_pend_tgt = 0; m_pend = 0; m_after_exc = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model, waits a cycle.
  task automatic cyc();
    logic [2:0]  e_ch;
    logic [31:0] e_tgt, n_pc, w_tgt;
    logic        e_fl, take_exc, w_any;
    logic [2:0]  w_ch;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      e_ch = 3'b000; e_tgt = EXC_VECTOR; e_fl = 1'b0; n_pc = m_pc; take_exc = 1'b0;
      w_any = 1'b1; w_ch = 3'b000; w_tgt = m_pc + 32'd4;
      if (eret_i)          begin w_ch = 3'b100; w_tgt = m_epc; end
      else if (jr_i)       begin w_ch = 3'b011; w_tgt = jr_tgt_i; end
      else if (jmp_i)      begin w_ch = 3'b010; w_tgt = jmp_tgt_i; end
      else if (br_taken_i) begin w_ch = 3'b001; w_tgt = br_tgt_i; end
      else w_any = 1'b0;

      chk("pc", pc_o, m_pc);
      chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
      chk("epc", epc_o, m_epc);

      if (m_after_exc) begin
        e_fl = 1'b1;
        if (!stall_i) n_pc = m_pc + 32'd4;
        m_after_exc = 0;
      end else if (m_pend) begin
        if (!stall_i) begin
          e_ch = 3'b100; e_tgt = m_pend_tgt; n_pc = m_pend_tgt; m_pend = 0;
        end else if (exc_i) take_exc = 1'b1;
      end else if (exc_i) begin
        take_exc = 1'b1;
      end else if (stall_i) begin
        if (w_any) begin m_pend = 1; m_pend_tgt = w_tgt; end
      end else begin
        e_ch = w_ch; n_pc = w_tgt;
        if (eret_i) e_tgt = m_epc;
      end

      if (take_exc) begin
        e_ch = 3'b100; e_tgt = EXC_VECTOR; n_pc = EXC_VECTOR;
        m_epc = exc_pc_i; m_pend = 0; m_after_exc = 1;
      end

      chk("choose", {29'd0, choose_o}, {29'd0, e_ch});
      chk("tgt_e", tgt_e_o, e_tgt);
      chk("flush", {31'd0, flush_o}, {31'd0, e_fl});
      m_pc = n_pc;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    stall_i = 0; br_taken_i = 0; jmp_i = 0; jr_i = 0; eret_i = 0; exc_i = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    idle();

    // Reset and free-run
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst_pc", pc_o, 32'h3000);
    chk("rst_epc", epc_o, 32'h0);
    cyc(); cyc();
    chk("run_pc", pc_o, 32'h3008);

    // jmp beats br
    br_taken_i = 1; br_tgt_i = 32'h3100; jmp_i = 1; jmp_tgt_i = 32'h3200;
    cyc(); idle();
    chk("jmp_pc", pc_o, 32'h3200);

    // jr latched during a 3-cycle stall, taken on release
    stall_i = 1; jr_i = 1; jr_tgt_i = 32'h3040; cyc();
    jr_i = 0; cyc(); cyc();
    chk("stall_pc", pc_o, 32'h3200);
    stall_i = 0; cyc();
    chk("pend_pc", pc_o, 32'h3040);

    // Exception overrides a stall
    stall_i = 1; exc_i = 1; exc_pc_i = 32'h3010; cyc(); idle();
    chk("exc_pc", pc_o, 32'h4180);
    chk("exc_epc", epc_o, 32'h3010);
    #1 chk("exc_flush", {31'd0, flush_o}, 32'd1);
    cyc();
    chk("exc_adv", pc_o, 32'h4184);

    // eret returns to EPC
    eret_i = 1; cyc(); idle();
    chk("eret_pc", pc_o, 32'h3010);

    // Reset while PEND drops the held target
    stall_i = 1; jr_i = 1; jr_tgt_i = 32'h5550; cyc(); idle();
    rst = 1; stall_i = 1; cyc(); rst = 0;
    chk("pend_rst_pc", pc_o, 32'h3000);
    stall_i = 0; cyc();
    chk("pend_rst_rel", pc_o, 32'h3004);

    // PC wrap through a jump to the last word
    jmp_i = 1; jmp_tgt_i = 32'hFFFF_FFFC; cyc(); idle();
    cyc();
    chk("wrap_pc", pc_o, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      stall_i    = ($urandom_range(0, 2) == 0);
      br_taken_i = ($urandom_range(0, 3) == 0);
      jmp_i      = ($urandom_range(0, 5) == 0);
      jr_i       = ($urandom_range(0, 5) == 0);
      eret_i     = ($urandom_range(0, 9) == 0);
      exc_i      = ($urandom_range(0, 14) == 0);
      exc_pc_i   = $urandom;
      br_tgt_i   = $urandom;
      jmp_tgt_i  = $urandom;
      jr_tgt_i   = $urandom;
      cyc();
    end
    rst = 0; idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
